// File: rtl/ks0108_sequencer.sv
// KS0108 panel bus sequencer: queues {data, dc, cs} bytes in a small FIFO and
// replays each one as a setup / E-strobe / hold cycle on the registered panel bus.
module ks0108_sequencer #(
    parameter int unsigned SETUP_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES = 13,
    parameter int unsigned HOLD_CYCLES  = 14,
    parameter int unsigned FIFO_BITS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] data_in,
    input  logic       dc_in,
    input  logic [1:0] cs_in,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    input  logic       overflow_clear,
    output logic       done,
    output logic [7:0] ks_data,
    output logic       ks_dc,
    output logic       ks_cs1,
    output logic       ks_cs2,
    output logic       ks_e
);

    localparam int unsigned DEPTH = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS:0] DEPTH_C   = (FIFO_BITS + 1)'(DEPTH);
    localparam logic [4:0]         SETUP_LD  = 5'(SETUP_CYCLES - 1);
    localparam logic [4:0]         PULSE_LD  = 5'(PULSE_CYCLES - 1);
    localparam logic [4:0]         HOLD_LD   = 5'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    logic [10:0]          r_mem [DEPTH];
    logic [FIFO_BITS-1:0] r_wptr;
    logic [FIFO_BITS-1:0] r_rptr;
    logic [FIFO_BITS:0]   r_count;
    state_t               r_state;
    logic [4:0]           r_cnt;
    logic                 r_overflow;
    logic                 r_done;
    logic [7:0]           r_data;
    logic                 r_dc;
    logic                 r_cs1;
    logic                 r_cs2;
    logic                 r_e;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [10:0]          w_head;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_push  = wr & ~w_full;
    // Pops happen from IDLE or on the final HOLD cycle, always on the pre-edge count.
    assign w_pop   = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_HOLD) & (r_cnt == '0)));
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {data_in, dc_in, cs_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (overflow_clear) begin
                r_overflow <= 1'b0;
            end else if (wr & w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_e     <= 1'b0;
            r_data  <= '0;
            r_dc    <= 1'b0;
            r_cs1   <= 1'b1;
            r_cs2   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_data, r_dc, r_cs1, r_cs2} <= w_head;
                        r_cnt   <= SETUP_LD;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_e     <= 1'b1;
                        r_cnt   <= PULSE_LD;
                        r_state <= S_STROBE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == '0) begin
                        r_e     <= 1'b0;
                        r_cnt   <= HOLD_LD;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_done <= 1'b1;
                        if (w_pop) begin
                            {r_data, r_dc, r_cs1, r_cs2} <= w_head;
                            r_cnt   <= SETUP_LD;
                            r_state <= S_SETUP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign full     = w_full;
    assign busy     = ~w_empty | (r_state != S_IDLE);
    assign overflow = r_overflow;
    assign done     = r_done;
    assign ks_data  = r_data;
    assign ks_dc    = r_dc;
    assign ks_cs1   = r_cs1;
    assign ks_cs2   = r_cs2;
    assign ks_e     = r_e;

endmodule

// File: tb/tb_ks0108_sequencer.sv
// Bench for ks0108_sequencer: transaction-level model (queue + cycles-since-load
// timeline) compared against every output on every cycle, plus pinned literals.
module tb_ks0108_sequencer;

    localparam int S = 4;
    localparam int P = 13;
    localparam int H = 14;
    localparam int FB = 2;
    localparam int D = 1 << FB;
    localparam int T = S + P + H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] data_in = '0;
    logic       dc_in = 1'b0;
    logic [1:0] cs_in = '0;
    logic       overflow_clear = 1'b0;
    logic       full, busy, overflow, done;
    logic [7:0] ks_data;
    logic       ks_dc, ks_cs1, ks_cs2, ks_e;

    always #5 clk = ~clk;

    ks0108_sequencer #(
        .SETUP_CYCLES(S),
        .PULSE_CYCLES(P),
        .HOLD_CYCLES (H),
        .FIFO_BITS   (FB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr            (wr),
        .data_in       (data_in),
        .dc_in         (dc_in),
        .cs_in         (cs_in),
        .full          (full),
        .busy          (busy),
        .overflow      (overflow),
        .overflow_clear(overflow_clear),
        .done          (done),
        .ks_data       (ks_data),
        .ks_dc         (ks_dc),
        .ks_cs1        (ks_cs1),
        .ks_cs2        (ks_cs2),
        .ks_e          (ks_e)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model: pending entries, and cycles elapsed since the current transfer loaded (-1 = none).
    logic [10:0] q[$];
    int          t = -1;
    logic [7:0]  m_data = '0;
    logic        m_dc = 1'b0, m_cs1 = 1'b1, m_cs2 = 1'b1;
    logic        m_ovf = 1'b0, m_done = 1'b0;

    always @(posedge clk) begin
        int pre_size;
        logic [10:0] e;
        if (reset) begin
            q.delete();
            t = -1;
            m_data = '0; m_dc = 1'b0; m_cs1 = 1'b1; m_cs2 = 1'b1;
            m_ovf = 1'b0; m_done = 1'b0;
        end else begin
            pre_size = q.size();
            m_done = 1'b0;
            if (t >= 0) begin
                if (t == T - 1) begin
                    m_done = 1'b1;
                    t = -1;
                end else begin
                    t++;
                end
            end
            if (t < 0 && pre_size > 0) begin
                e = q.pop_front();
                m_data = e[10:3];
                m_dc   = e[2];
                m_cs1  = e[1];
                m_cs2  = e[0];
                t = 0;
            end
            if (wr && pre_size < D) q.push_back({data_in, dc_in, cs_in});
            if (overflow_clear) m_ovf = 1'b0;
            else if (wr && pre_size == D) m_ovf = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("full", 32'(full), 32'(q.size() == D));
            chk("busy", 32'(busy), 32'(q.size() > 0 || t >= 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("done", 32'(done), 32'(m_done));
            chk("ks_e", 32'(ks_e), 32'(t >= S && t < S + P));
            chk("ks_data", 32'(ks_data), 32'(m_data));
            chk("ks_dc", 32'(ks_dc), 32'(m_dc));
            chk("ks_cs1", 32'(ks_cs1), 32'(m_cs1));
            chk("ks_cs2", 32'(ks_cs2), 32'(m_cs2));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d, input logic dc, input logic [1:0] cs);
        wr = 1'b1; data_in = d; dc_in = dc; cs_in = cs;
        step();
        wr = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 2000 && busy !== 1'b0; i++) step();
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        step(2);
        chk_en = 1'b1;
        chk("rst_cs1", 32'(ks_cs1), 32'd1);
        chk("rst_cs2", 32'(ks_cs2), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ke", 32'(ks_e), 32'd0);
        reset = 1'b0;
        step();

        // Single write: edge 0 accept, load at edge 1, E high after edges 5..17, done with idle at edge 32.
        push(8'h3F, 1'b0, 2'b01);
        step();
        chk("single_data", 32'(ks_data), 32'h3F);
        chk("single_cs", 32'({ks_dc, ks_cs1, ks_cs2}), 32'b001);
        step(3);
        chk("single_e4", 32'(ks_e), 32'd0);
        step();
        chk("single_e5", 32'(ks_e), 32'd1);
        step(12);
        chk("single_e17", 32'(ks_e), 32'd1);
        step();
        chk("single_e18", 32'(ks_e), 32'd0);
        step(13);
        chk("single_done31", 32'({done, busy}), 32'b01);
        step();
        chk("single_done32", 32'({done, busy}), 32'b10);
        step(3);

        // Burst of four while busy so all stay queued: full after the fourth.
        push(8'h11, 1'b1, 2'b10);
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1'b1, 2'b10);
        chk("burst_full", 32'(full), 32'd1);
        drain();

        // Six back-to-back writes: first pops at once, sixth meets a full FIFO.
        for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i), 1'b0, 2'b11);
        chk("ovf_set", 32'(overflow), 32'd1);
        // Clear wins over a same-edge dropped push.
        wr = 1'b1; overflow_clear = 1'b1; step();
        wr = 1'b0; overflow_clear = 1'b0;
        chk("ovf_clear_prio", 32'(overflow), 32'd0);
        drain();

        // Reset during the strobe kills E and the queue.
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 1'b1, 2'b00);
        for (int i = 0; i < 50 && ks_e !== 1'b1; i++) step();
        chk("strobe_reached", 32'(ks_e), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("midrst", 32'({ks_e, ks_cs1, ks_cs2, busy}), 32'b0110);
        step(40);

        // Randomised traffic with varying write density, rare clears and resets.
        for (int blk = 0; blk < 6; blk++) begin
            int dens = int'($urandom_range(1, 12));
            for (int c = 0; c < 600; c++) begin
                wr = ($urandom_range(0, dens - 1) == 0);
                data_in = 8'($urandom);
                dc_in = 1'($urandom);
                cs_in = 2'($urandom);
                overflow_clear = ($urandom_range(0, 40) == 0);
                reset = ($urandom_range(0, 700) == 0);
                step();
            end
            wr = 1'b0; overflow_clear = 1'b0; reset = 1'b0;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
